// File: rtl/ram_io_pkg.sv
// ram_io_pkg: shared encodings, FSM state type and lane helpers for ram_io.
//   - SZ_* : access size code used by write_type and read_type[1:0]
//   - RD_SIGN : bit of read_type that requests sign extension
//   - state_e : ram_io controller states
//   - lane_extract : right-align a byte/half/word out of a RAM word
//   - lane_merge   : insert a byte/half/word into an existing RAM word
package ram_io_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int unsigned RD_SIGN = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_RMW_RD,
    ST_RMW_WR
  } state_e;

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  rtype);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (rtype[1:0])
      SZ_BYTE: r = {{24{rtype[RD_SIGN] & b[7]}}, b};
      SZ_HALF: r = {{16{rtype[RD_SIGN] & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [1:0]  lane,
                                             input logic [31:0] data,
                                             input logic [1:0]  wtype);
    logic [31:0] r;
    r = old_word;
    case (wtype)
      SZ_BYTE: r[{lane, 3'b000} +: 8]     = data[7:0];
      SZ_HALF: r[{lane[1], 4'b0000} +: 16] = data[15:0];
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ram_word_sp.sv
// ram_word_sp: single-port DEPTH_WORDS x 32 RAM, registered read, one write.
//   clk   : clock
//   addr  : word address shared by read and write
//   we    : write wdata to addr
//   re    : load rdata from addr (rdata holds otherwise)
//   wdata : write data
//   rdata : registered read data
module ram_word_sp #(
  parameter int unsigned DEPTH_WORDS = 2048
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic                           we,
  input  logic                           re,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_io.sv
// ram_io: memory/IO slave on the core's RAMIO port. Word-wide block RAM with
// byte/half/word reads (optional sign extension), direct word writes and
// read-modify-write byte/half writes.
//   clk, rst        : clock, synchronous active-high reset
//   enable          : request valid
//   read_type[2:0]  : [1:0] size (01 byte, 10 half, 11 word), [2] sign-extend
//   write_type[1:0] : 00 none, 01 byte, 10 half, 11 word (wins over read)
//   address[31:0]   : byte address, little-endian, word index wraps
//   data_in[31:0]   : right-aligned write data
//   data_out[31:0]  : right-aligned read data
//   data_out_ready  : data_out belongs to the currently presented read
//   busy            : presented write not yet completed
//   led[5:0]        : LED register, active-low
// Optional feature: define RAMIO_LED_EN to map LED_ADDR onto the led register.
module ram_io #(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter logic [31:0] LED_ADDR    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  read_type,
  input  logic [1:0]  write_type,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_ready,
  output logic        busy,
  output logic [5:0]  led
);
  import ram_io_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [2:0]  rd_type_q, rd_type_d;
  logic        wack_q, wack_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [1:0]  wr_type_q, wr_type_d;

  logic [AW-1:0] ram_addr;
  logic          ram_we, ram_re;
  logic [31:0]   ram_wdata, ram_rdata;

  logic          req_read, new_write, in_rmw, led_hit;
  logic [AW-1:0] req_idx;
  logic [31:0]   rd_src;
  logic [1:0]    rd_lane;

`ifdef RAMIO_LED_EN
  logic [5:0] led_q, led_d;
  logic       rd_led_q, rd_led_d;
  assign led_hit = (address == LED_ADDR);
  assign led     = led_q;
  // The led register is already right-aligned, so it is extracted as lane 0.
  assign rd_src  = rd_led_q ? {26'b0, led_q} : ram_rdata;
  assign rd_lane = rd_led_q ? 2'b00 : rd_addr_q[1:0];
`else
  assign led_hit = 1'b0;
  assign led     = '1;
  assign rd_src  = ram_rdata;
  assign rd_lane = rd_addr_q[1:0];
`endif

  ram_word_sp #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .re    (ram_re),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign req_idx   = address[AW+1:2];
  assign in_rmw    = (state_q == ST_RMW_RD) || (state_q == ST_RMW_WR);
  assign req_read  = enable && (write_type == SZ_NONE) && (read_type[1:0] != SZ_NONE);
  // A write identical to the last completed one is absorbed, not re-executed.
  assign new_write = enable && (write_type != SZ_NONE) &&
                     !(wack_q && address == wr_addr_q && data_in == wr_data_q &&
                       write_type == wr_type_q);
  assign busy      = in_rmw || new_write;

  assign data_out       = ready_q ? lane_extract(rd_src, rd_lane, rd_type_q) : '0;
  assign data_out_ready = ready_q && req_read && address == rd_addr_q &&
                          read_type == rd_type_q;

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    rd_addr_d = rd_addr_q;
    rd_type_d = rd_type_q;
    wack_d    = wack_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_type_d = wr_type_q;
`ifdef RAMIO_LED_EN
    led_d     = led_q;
    rd_led_d  = rd_led_q;
`endif
    ram_addr  = req_idx;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_wdata = data_in;
    if (!rst) begin
      case (state_q)
        // The old word arrives on the RAM output during RMW_RD, so the merge
        // and the write share that cycle and the controller returns to IDLE.
        ST_RMW_RD, ST_RMW_WR: begin
          ram_addr  = wr_addr_q[AW+1:2];
          ram_we    = 1'b1;
          ram_wdata = lane_merge(ram_rdata, wr_addr_q[1:0], wr_data_q, wr_type_q);
          wack_d    = 1'b1;
          state_d   = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          if (new_write) begin
            wr_addr_d = address;
            wr_data_d = data_in;
            wr_type_d = write_type;
            if (led_hit) begin
`ifdef RAMIO_LED_EN
              led_d = data_in[5:0];
`endif
              wack_d  = 1'b1;
              ready_d = 1'b0;
            end else if (write_type == SZ_WORD) begin
              ram_we = 1'b1;
              wack_d = 1'b1;
              if (req_idx == rd_addr_q[AW+1:2]) ready_d = 1'b0;
            end else begin
              // The RMW read overwrites the RAM output register, so any held
              // read result is no longer available.
              ram_re  = 1'b1;
              wack_d  = 1'b0;
              ready_d = 1'b0;
              state_d = ST_RMW_RD;
            end
          end else if (req_read) begin
            ram_re    = 1'b1;
            rd_addr_d = address;
            rd_type_d = read_type;
            ready_d   = 1'b1;
`ifdef RAMIO_LED_EN
            rd_led_d  = led_hit;
`endif
            state_d   = ST_RD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_type_q <= '0;
      wack_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_type_q <= '0;
`ifdef RAMIO_LED_EN
      led_q     <= '1;
      rd_led_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      rd_addr_q <= rd_addr_d;
      rd_type_q <= rd_type_d;
      wack_q    <= wack_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_type_q <= wr_type_d;
`ifdef RAMIO_LED_EN
      led_q     <= led_d;
      rd_led_q  <= rd_led_d;
`endif
    end
  end

endmodule
